// File: rtl/pe_mac_sys.sv
// rtl/pe_mac_sys.sv - weight-stationary systolic PE with double-buffered weight and handshaked result
module pe_mac_sys #(
  parameter int DATA_W   = 8,
  parameter int WGT_W    = 8,
  parameter int ACC_W    = 20,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_load,
  input  logic [WGT_W-1:0]  w_in,
  input  logic              w_swap,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              fwd_valid,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_sat,
  input  logic              err_clr,
  output logic              ovr_err
);

  localparam int PW = DATA_W + WGT_W;
  localparam int SW = ACC_W + 1;

  generate
    if (ACC_W < PW) begin : g_acc_w_check
      $error("pe_mac_sys: ACC_W must be at least DATA_W+WGT_W");
    end
  endgenerate

  typedef enum logic {ACC_IDLE, ACC_RUN} acc_st_t;
  typedef enum logic {RES_EMPTY, RES_FULL} res_st_t;

  acc_st_t          acc_st;
  res_st_t          res_st;
  logic [WGT_W-1:0] w_sh;
  logic [WGT_W-1:0] w_act;
  logic [ACC_W-1:0] acc;
  logic             sat_acc;

  logic             sgn;
  logic             done;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    b_ext;
  logic [PW-1:0]    prod;
  logic [SW-1:0]    prod_x;
  logic [SW-1:0]    acc_x;
  logic [SW-1:0]    sum;
  logic [ACC_W-1:0] acc_base;
  logic             sat_base;
  logic             ovf;
  logic [ACC_W-1:0] sum_acc;
  logic             sum_sat;

  assign sgn  = (SIGNED != 0);
  assign done = in_valid & in_last;

  // Multiply and add at ACC_W+1 bits, then clamp or wrap into the accumulator width
  always_comb begin
    a_ext    = {{WGT_W{sgn & in_data[DATA_W-1]}}, in_data};
    b_ext    = {{DATA_W{sgn & w_act[WGT_W-1]}}, w_act};
    prod     = a_ext * b_ext;
    prod_x   = {{(SW-PW){sgn & prod[PW-1]}}, prod};
    acc_base = (acc_st == ACC_RUN) ? acc : '0;
    sat_base = (acc_st == ACC_RUN) ? sat_acc : 1'b0;
    acc_x    = {sgn & acc_base[ACC_W-1], acc_base};
    sum      = acc_x + prod_x;
    ovf      = sgn ? (sum[SW-1] ^ sum[SW-2]) : sum[SW-1];
    sum_acc  = sum[ACC_W-1:0];
    sum_sat  = sat_base;
    if ((SATURATE != 0) && ovf) begin
      sum_sat = 1'b1;
      if (sgn) begin
        sum_acc = sum[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        sum_acc = '1;
      end
    end
  end

  // Shadow/active weight pair; swap copies the pre-load shadow value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_sh  <= '0;
      w_act <= '0;
    end else begin
      if (w_load) w_sh <= w_in;
      if (w_swap) w_act <= w_sh;
    end
  end

  // Unconditional one-stage forwarding to the east neighbour
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_valid <= 1'b0;
      fwd_data  <= '0;
      fwd_last  <= 1'b0;
    end else begin
      fwd_valid <= in_valid;
      fwd_data  <= in_data;
      fwd_last  <= in_last;
    end
  end

  // Accumulator FSM: accumulate while running, restart from zero on every completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_st  <= ACC_IDLE;
      acc     <= '0;
      sat_acc <= 1'b0;
    end else if (in_valid) begin
      if (in_last) begin
        acc_st  <= ACC_IDLE;
        acc     <= '0;
        sat_acc <= 1'b0;
      end else begin
        acc_st  <= ACC_RUN;
        acc     <= sum_acc;
        sat_acc <= sum_sat;
      end
    end
  end

  // Single-entry result holding stage; a completion that finds it full and stalled is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_st    <= RES_EMPTY;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_sat   <= 1'b0;
      ovr_err   <= 1'b0;
    end else begin
      if (res_st == RES_EMPTY) begin
        if (done) begin
          res_st    <= RES_FULL;
          res_valid <= 1'b1;
          res_data  <= sum_acc;
          res_sat   <= sum_sat;
        end
      end else begin
        if (done && res_ready) begin
          res_data <= sum_acc;
          res_sat  <= sum_sat;
        end else if (!done && res_ready) begin
          res_st    <= RES_EMPTY;
          res_valid <= 1'b0;
        end
      end
      if (done && (res_st == RES_FULL) && !res_ready) begin
        ovr_err <= 1'b1;
      end else if (err_clr) begin
        ovr_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_sys.sv
// tb/tb_pe_mac_sys.sv - directed vector bench for pe_mac_sys
module tb_pe_mac_sys;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       w_load = 1'b0;
  logic [7:0] w_in = '0;
  logic       w_swap = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       res_ready = 1'b0;
  logic       err_clr = 1'b0;

  // d0: defaults; d1: unsigned; d2: 16-bit saturating; d3: 16-bit wrapping
  logic        f0_v, f1_v, f2_v, f3_v;
  logic [7:0]  f0_d, f1_d, f2_d, f3_d;
  logic        f0_l, f1_l, f2_l, f3_l;
  logic        r0_v, r1_v, r2_v, r3_v;
  logic [19:0] r0_d, r1_d;
  logic [15:0] r2_d, r3_d;
  logic        r0_s, r1_s, r2_s, r3_s;
  logic        e0, e1, e2, e3;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pe_mac_sys d0 (
    .clk(clk), .rst(rst), .w_load(w_load), .w_in(w_in), .w_swap(w_swap),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .fwd_valid(f0_v), .fwd_data(f0_d), .fwd_last(f0_l),
    .res_valid(r0_v), .res_ready(res_ready), .res_data(r0_d), .res_sat(r0_s),
    .err_clr(err_clr), .ovr_err(e0)
  );

  pe_mac_sys #(.SIGNED(0)) d1 (
    .clk(clk), .rst(rst), .w_load(w_load), .w_in(w_in), .w_swap(w_swap),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .fwd_valid(f1_v), .fwd_data(f1_d), .fwd_last(f1_l),
    .res_valid(r1_v), .res_ready(res_ready), .res_data(r1_d), .res_sat(r1_s),
    .err_clr(err_clr), .ovr_err(e1)
  );

  pe_mac_sys #(.ACC_W(16)) d2 (
    .clk(clk), .rst(rst), .w_load(w_load), .w_in(w_in), .w_swap(w_swap),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .fwd_valid(f2_v), .fwd_data(f2_d), .fwd_last(f2_l),
    .res_valid(r2_v), .res_ready(res_ready), .res_data(r2_d), .res_sat(r2_s),
    .err_clr(err_clr), .ovr_err(e2)
  );

  pe_mac_sys #(.ACC_W(16), .SATURATE(0)) d3 (
    .clk(clk), .rst(rst), .w_load(w_load), .w_in(w_in), .w_swap(w_swap),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .fwd_valid(f3_v), .fwd_data(f3_d), .fwd_last(f3_l),
    .res_valid(r3_v), .res_ready(res_ready), .res_data(r3_d), .res_sat(r3_s),
    .err_clr(err_clr), .ovr_err(e3)
  );

  typedef struct {
    logic        wl;
    logic [7:0]  wi;
    logic        ws;
    logic        iv;
    logic [7:0]  id;
    logic        il;
    logic        rr;
    logic        ec;
    logic        erv;
    logic [19:0] erd;
    logic        ers;
    logic        eoe;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic wl, input logic [7:0] wi, input logic ws,
                              input logic iv, input logic [7:0] id, input logic il,
                              input logic rr, input logic ec, input logic erv,
                              input logic [19:0] erd, input logic ers, input logic eoe);
    vec_t v;
    v.wl = wl; v.wi = wi; v.ws = ws; v.iv = iv; v.id = id; v.il = il;
    v.rr = rr; v.ec = ec; v.erv = erv; v.erd = erd; v.ers = ers; v.eoe = eoe;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wl, input logic [7:0] wi, input logic ws, input logic iv,
                       input logic [7:0] id, input logic il, input logic rr, input logic ec);
    w_load = wl; w_in = wi; w_swap = ws; in_valid = iv;
    in_data = id; in_last = il; res_ready = rr; err_clr = ec;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_d0_zero(input string tag);
    chk({tag, " res_valid"}, {31'b0, r0_v}, 32'd0);
    chk({tag, " res_data"},  {12'b0, r0_d}, 32'd0);
    chk({tag, " res_sat"},   {31'b0, r0_s}, 32'd0);
    chk({tag, " ovr_err"},   {31'b0, e0},   32'd0);
    chk({tag, " fwd_valid"}, {31'b0, f0_v}, 32'd0);
    chk({tag, " fwd_data"},  {24'b0, f0_d}, 32'd0);
    chk({tag, " fwd_last"},  {31'b0, f0_l}, 32'd0);
  endtask

  initial begin
    // weight 3, stream 1,2,3 -> 18
    tbl.push_back(mk(1, 8'h03, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 3, 1, 1, 0, 1, 20'd18, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // weight -2, single operand 5 -> -10
    tbl.push_back(mk(1, 8'hFE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 5, 1, 0, 0, 1, 20'hFFFF6, 0, 0));
    // weight 2, back-pressure: 6 held, 10 dropped, clear, then 8 replaces 6
    tbl.push_back(mk(1, 8'h02, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 3, 1, 0, 0, 1, 20'd6, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 5, 1, 0, 0, 1, 20'd6, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 20'd6, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 4, 1, 1, 0, 1, 20'd8, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // drop and err_clr together: set wins
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 1, 0, 0, 1, 20'd2, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 1, 0, 1, 1, 20'd2, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    // one result per cycle with res_ready high
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 1, 1, 0, 1, 20'd2, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 2, 1, 1, 0, 1, 20'd4, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // double buffer: 1*2 + 1*2 (swap here) + 1*5 + 1*5 = 14
    tbl.push_back(mk(1, 8'h05, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 1, 0, 0, 1, 20'd14, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // in_last without in_valid is not a completion
    tbl.push_back(mk(0, 8'h00, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 1, 0, 0, 1, 20'd5, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_d0_zero("reset");
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].wl, tbl[i].wi, tbl[i].ws, tbl[i].iv, tbl[i].id, tbl[i].il, tbl[i].rr, tbl[i].ec);
      tick();
      chk($sformatf("v%0d res_valid", i), {31'b0, r0_v}, {31'b0, tbl[i].erv});
      chk($sformatf("v%0d ovr_err", i), {31'b0, e0}, {31'b0, tbl[i].eoe});
      chk($sformatf("v%0d fwd_valid", i), {31'b0, f0_v}, {31'b0, tbl[i].iv});
      chk($sformatf("v%0d fwd_data", i), {24'b0, f0_d}, {24'b0, tbl[i].id});
      chk($sformatf("v%0d fwd_last", i), {31'b0, f0_l}, {31'b0, tbl[i].il});
      if (tbl[i].erv) begin
        chk($sformatf("v%0d res_data", i), {12'b0, r0_d}, {12'b0, tbl[i].erd});
        chk($sformatf("v%0d res_sat", i), {31'b0, r0_s}, {31'b0, tbl[i].ers});
      end
    end

    // unsigned: 254 * 5 = 1270
    drive(1, 8'hFE, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 8'h00, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 8'h00, 0, 1, 5, 1, 0, 0); tick();
    chk("unsigned res_valid", {31'b0, r1_v}, 32'd1);
    chk("unsigned res_data", {12'b0, r1_d}, 32'd1270);
    chk("unsigned res_sat", {31'b0, r1_s}, 32'd0);
    drive(0, 8'h00, 0, 0, 0, 0, 1, 0); tick();

    // 127*127 three times: clamps at 16 bits, wraps without saturation
    drive(1, 8'h7F, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 8'h00, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 8'h00, 0, 1, 127, 0, 0, 0); tick();
    drive(0, 8'h00, 0, 1, 127, 0, 0, 0); tick();
    drive(0, 8'h00, 0, 1, 127, 1, 0, 0); tick();
    chk("sat16 res_valid", {31'b0, r2_v}, 32'd1);
    chk("sat16 res_data", {16'b0, r2_d}, 32'h7FFF);
    chk("sat16 res_sat", {31'b0, r2_s}, 32'd1);
    chk("wrap16 res_data", {16'b0, r3_d}, 32'hBD03);
    chk("wrap16 res_sat", {31'b0, r3_s}, 32'd0);
    chk("acc20 res_data", {12'b0, r0_d}, 32'd48387);
    chk("acc20 res_sat", {31'b0, r0_s}, 32'd0);
    drive(0, 8'h00, 0, 0, 0, 0, 1, 0); tick();
    drive(0, 8'h00, 0, 1, 1, 1, 0, 0); tick();
    chk("sat16 next res_data", {16'b0, r2_d}, 32'd127);
    chk("sat16 next res_sat", {31'b0, r2_s}, 32'd0);
    drive(0, 8'h00, 0, 0, 0, 0, 1, 0); tick();

    // reset with a held result, a dropped result and a partial sum in flight
    drive(0, 8'h00, 0, 1, 1, 1, 0, 0); tick();
    drive(0, 8'h00, 0, 1, 1, 1, 0, 0); tick();
    chk("pre-reset ovr_err", {31'b0, e0}, 32'd1);
    drive(0, 8'h00, 0, 1, 2, 0, 0, 0); tick();
    drive(0, 8'h00, 0, 1, 3, 0, 0, 0); tick();
    drive(0, 8'h00, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #2;
    chk_d0_zero("midreset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    drive(0, 8'h00, 0, 1, 4, 1, 1, 0); tick();
    chk("post-reset w0 res_valid", {31'b0, r0_v}, 32'd1);
    chk("post-reset w0 res_data", {12'b0, r0_d}, 32'd0);
    drive(1, 8'h01, 0, 0, 0, 0, 1, 0); tick();
    drive(0, 8'h00, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 8'h00, 0, 1, 4, 1, 0, 0); tick();
    chk("post-reset res_valid", {31'b0, r0_v}, 32'd1);
    chk("post-reset res_data", {12'b0, r0_d}, 32'd4);
    chk("post-reset res_sat", {31'b0, r0_s}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
